// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_req;
   logic              mem_rd_ack;
   logic [DATA_W-1:0] mem_rd_data;

   modport master (
      output mem_addr,
      output mem_rd_req,
      input  mem_rd_ack,
      input  mem_rd_data
   );

   modport slave (
      input  mem_addr,
      input  mem_rd_req,
      output mem_rd_ack,
      output mem_rd_data
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues reads at current_PC, buffers one fetched word
// for decode and computes the sequential or branch next PC for the PC register.
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter logic [15:0] PC_STEP      = 16'd2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              current_PC,
   output logic [15:0]              new_PC,
   instruction_fetch_unit_if.master mem,
   input  logic                     branch_valid,
   input  logic [15:0]              branch_target,
   input  logic                     halt,
   input  logic                     stall,
   output logic [15:0]              instr_out,
   output logic                     instr_valid
);

   localparam int unsigned PC_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] new_pc_q, new_pc_d;
   logic [PC_W-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            br_pend_q, br_pend_d;

   logic            rd_req_c;
   logic            ack_acc_c;

   // Request whenever running, not halted, and the output buffer can take a word.
   always_comb begin
      rd_req_c  = (state_q == ST_RUN) && !halt && !(valid_q && stall);
      ack_acc_c = rd_req_c && mem.mem_rd_ack;
   end

   assign mem.mem_addr   = current_PC;
   assign mem.mem_rd_req = rd_req_c;

   // State and datapath registers; reset discards any outstanding read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         new_pc_q  <= RESET_VECTOR;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         br_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         new_pc_q  <= new_pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         br_pend_q <= br_pend_d;
      end
   end

   // Next state, next PC, output buffer and pending-branch bookkeeping.
   always_comb begin
      state_d   = state_q;
      new_pc_d  = new_pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      br_pend_d = br_pend_q;

      unique case (state_q)
         ST_IDLE:   state_d = ST_RUN;
         ST_RUN:    if (halt)  state_d = ST_HALTED;
         ST_HALTED: if (!halt) state_d = ST_RUN;
         default:   state_d = ST_IDLE;
      endcase

      // An outstanding read is abandoned on entry to HALTED; nothing to discard later.
      if (state_q == ST_RUN && halt) begin
         br_pend_d = 1'b0;
      end

      // Decode takes the buffered word.
      if (valid_q && !stall) begin
         valid_d = 1'b0;
      end

      if (branch_valid) begin
         // Target wins over any fetched or buffered word.
         new_pc_d = branch_target;
         valid_d  = 1'b0;
         if (rd_req_c && !mem.mem_rd_ack) begin
            br_pend_d = 1'b1;
         end else if (ack_acc_c) begin
            br_pend_d = 1'b0;
         end
      end else if (ack_acc_c) begin
         if (br_pend_q) begin
            // Word belongs to the pre-branch path: drop it.
            br_pend_d = 1'b0;
         end else begin
            instr_d  = mem.mem_rd_data;
            valid_d  = 1'b1;
            new_pc_d = PC_W'(current_PC + PC_STEP);
         end
      end
   end

   assign new_PC      = new_pc_q;
   assign instr_out   = instr_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a PC-register model and a
// wait-state memory model returning ~address as the instruction word.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic [15:0] current_PC;
   logic [15:0] new_PC;
   logic        branch_valid;
   logic [15:0] branch_target;
   logic        halt;
   logic        stall;
   logic [15:0] instr_out;
   logic        instr_valid;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(
      .RESET_VECTOR (16'h0000),
      .PC_STEP      (16'd2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .current_PC    (current_PC),
      .new_PC        (new_PC),
      .mem           (bus),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .halt          (halt),
      .stall         (stall),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid)
   );

   int          n_cmp;
   int          n_err;
   int unsigned waits;
   int unsigned wait_cnt;
   logic        force_ack;
   logic        data_ovr_en;
   logic [15:0] data_ovr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register: loads new_PC on the negedge.
   always @(negedge clk) current_PC <= new_PC;

   // Memory: acks after 'waits' cycles of continuous request.
   assign bus.mem_rd_ack  = force_ack | (bus.mem_rd_req && (wait_cnt == waits));
   assign bus.mem_rd_data = data_ovr_en ? data_ovr : ~bus.mem_addr;

   always @(posedge clk or posedge rst) begin
      if (rst) wait_cnt <= 0;
      else if (!bus.mem_rd_req || bus.mem_rd_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] e;
      n_cmp = 0; n_err = 0;
      rst = 1'b1; current_PC = 16'h0000;
      branch_valid = 1'b0; branch_target = 16'h0000;
      halt = 1'b0; stall = 1'b0;
      waits = 0; force_ack = 1'b0; data_ovr_en = 1'b0; data_ovr = 16'h0000;

      // 1: reset, then zero-wait free run
      tick(); tick();
      check_eq("rst_new_pc", new_PC, 16'h0000);
      check_eq("rst_valid", 16'(instr_valid), 16'h0);
      check_eq("rst_instr", instr_out, 16'h0000);
      check_eq("rst_req", 16'(bus.mem_rd_req), 16'h0);
      rst = 1'b0;
      tick();
      check_eq("run_req", 16'(bus.mem_rd_req), 16'h1);
      check_eq("run_addr", bus.mem_addr, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         e = 16'(2 * i);
         check_eq("seq_instr", instr_out, ~e);
         check_eq("seq_valid", 16'(instr_valid), 16'h1);
         check_eq("seq_new_pc", new_PC, 16'(2 * i + 2));
      end

      // 2: two wait states
      waits = 2;
      for (int k = 0; k < 2; k++) begin
         e = 16'(8 + 2 * k);
         for (int w = 0; w < 2; w++) begin
            tick();
            check_eq("ws_valid", 16'(instr_valid), 16'h0);
            check_eq("ws_new_pc", new_PC, e);
            at_neg();
            check_eq("ws_addr", bus.mem_addr, e);
            check_eq("ws_req", 16'(bus.mem_rd_req), 16'h1);
         end
         tick();
         check_eq("ws_instr", instr_out, ~e);
         check_eq("ws_valid_ack", 16'(instr_valid), 16'h1);
         check_eq("ws_new_pc_ack", new_PC, 16'(e + 16'd2));
      end

      // 3: stall with a full buffer
      waits = 0; stall = 1'b1;
      for (int s = 0; s < 4; s++) begin
         at_neg();
         check_eq("stall_req", 16'(bus.mem_rd_req), 16'h0);
         tick();
         check_eq("stall_instr", instr_out, ~16'd10);
         check_eq("stall_valid", 16'(instr_valid), 16'h1);
         check_eq("stall_new_pc", new_PC, 16'd12);
      end
      stall = 1'b0;
      tick();
      check_eq("unstall_instr", instr_out, ~16'd12);
      check_eq("unstall_new_pc", new_PC, 16'd14);

      // 4: branch during a wait, stale ack carries DEAD
      waits = 2;
      tick();
      check_eq("br_pre_valid", 16'(instr_valid), 16'h0);
      branch_valid = 1'b1; branch_target = 16'h0100;
      tick();
      branch_valid = 1'b0;
      check_eq("br_new_pc", new_PC, 16'h0100);
      check_eq("br_valid", 16'(instr_valid), 16'h0);
      data_ovr_en = 1'b1; data_ovr = 16'hDEAD;
      tick();
      check_eq("br_drop_valid", 16'(instr_valid), 16'h0);
      check_eq("br_drop_new_pc", new_PC, 16'h0100);
      data_ovr_en = 1'b0;
      at_neg();
      check_eq("br_addr", bus.mem_addr, 16'h0100);
      check_eq("br_req", 16'(bus.mem_rd_req), 16'h1);
      tick();
      check_eq("br_w1_valid", 16'(instr_valid), 16'h0);
      tick();
      check_eq("br_w2_valid", 16'(instr_valid), 16'h0);
      tick();
      check_eq("br_tgt_instr", instr_out, 16'hFEFF);
      check_eq("br_tgt_valid", 16'(instr_valid), 16'h1);
      check_eq("br_tgt_new_pc", new_PC, 16'h0102);

      // 5: branch coincident with ack, then wrap at FFFE
      waits = 0;
      branch_valid = 1'b1; branch_target = 16'hFFFE;
      tick();
      branch_valid = 1'b0;
      check_eq("co_valid", 16'(instr_valid), 16'h0);
      check_eq("co_new_pc", new_PC, 16'hFFFE);
      tick();
      check_eq("wrap_instr", instr_out, 16'h0001);
      check_eq("wrap_new_pc", new_PC, 16'h0000);
      tick();
      check_eq("wrap_next_instr", instr_out, 16'hFFFF);
      check_eq("wrap_next_new_pc", new_PC, 16'h0002);

      // 7: halt with a buffered word being consumed
      halt = 1'b1;
      tick();
      check_eq("halt_valid", 16'(instr_valid), 16'h0);
      check_eq("halt_instr", instr_out, 16'hFFFF);
      check_eq("halt_new_pc", new_PC, 16'h0002);
      for (int h = 0; h < 3; h++) begin
         at_neg();
         check_eq("halt_req", 16'(bus.mem_rd_req), 16'h0);
         tick();
         check_eq("halt_hold_pc", new_PC, 16'h0002);
         check_eq("halt_hold_valid", 16'(instr_valid), 16'h0);
      end
      halt = 1'b0;
      tick();
      check_eq("resume_valid", 16'(instr_valid), 16'h0);
      at_neg();
      check_eq("resume_req", 16'(bus.mem_rd_req), 16'h1);
      check_eq("resume_addr", bus.mem_addr, 16'h0002);
      tick();
      check_eq("resume_instr", instr_out, 16'hFFFD);
      check_eq("resume_new_pc", new_PC, 16'h0004);

      // 6: reset mid-request, late ack during reset
      waits = 2;
      tick();
      #2 rst = 1'b1;
      #1;
      check_eq("arst_new_pc", new_PC, 16'h0000);
      check_eq("arst_valid", 16'(instr_valid), 16'h0);
      check_eq("arst_instr", instr_out, 16'h0000);
      check_eq("arst_req", 16'(bus.mem_rd_req), 16'h0);
      force_ack = 1'b1; data_ovr_en = 1'b1; data_ovr = 16'hDEAD;
      for (int r = 0; r < 2; r++) begin
         tick();
         check_eq("late_ack_valid", 16'(instr_valid), 16'h0);
         check_eq("late_ack_instr", instr_out, 16'h0000);
      end
      force_ack = 1'b0; data_ovr_en = 1'b0;
      rst = 1'b0;
      tick();
      check_eq("rel_valid", 16'(instr_valid), 16'h0);
      at_neg();
      check_eq("rel_addr", bus.mem_addr, 16'h0000);
      check_eq("rel_req", 16'(bus.mem_rd_req), 16'h1);
      tick();
      tick();
      check_eq("rel_wait_valid", 16'(instr_valid), 16'h0);
      tick();
      check_eq("rel_instr", instr_out, 16'hFFFF);
      check_eq("rel_new_pc", new_PC, 16'h0002);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
